qbus_slave_cycle: RTL and testbench

Qbus slave-cycle controller for the bus interface: synchronizes the asynchronous Qbus control lines to `qclk`, latches the address phase, and runs the slave side of the DATI, DATO(B) and DATIO(B) handshakes. It sits directly upstream of every I/O-page device register (switch register, RKV11 registers, ...). It supplies their latched address (`RAL`, `RBS7`), write data (`RDL`) and `write_pulse`, collects their `addr_match`, and drives the reply and data-driver enables back to the bus transceivers.

---
 rtl/qbus_slave_cycle.sv | 226 ++++++++++++++++++++++
 tb/tb_qbus_slave_cycle.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_slave_cycle.sv
// qbus_slave_cycle: Qbus slave-cycle controller.
// Synchronizes the asynchronous bus control lines to qclk, latches the
// address phase and runs the slave side of DATI, DATO(B) and DATIO(B).
// Ports:
//   qclk, reset            - 20 MHz clock, synchronous active-high reset
//   BDAL, BBS7             - raw DAL / BS7 receiver outputs
//   BSYNC, BDIN, BDOUT,
//   BWTBT                  - raw asynchronous control receivers
//   dev_match              - OR of device address decoders
//   RAL, RBS7, RDL         - latched address, BS7 and write data
//   write_pulse,
//   write_lo, write_hi     - one-cycle write strobe and byte-lane enables
//   read_cycle, TDL_EN     - DATI in progress / device data driver enable
//   TRPLY                  - bus RPLY driver
`timescale 1ns/1ps
module qbus_slave_cycle #(
  parameter int unsigned READ_SETUP = 2
) (
  input  logic        qclk,
  input  logic        reset,
  input  logic [21:0] BDAL,
  input  logic        BBS7,
  input  logic        BSYNC,
  input  logic        BDIN,
  input  logic        BDOUT,
  input  logic        BWTBT,
  input  logic        dev_match,
  output logic [21:0] RAL,
  output logic        RBS7,
  output logic [15:0] RDL,
  output logic        write_pulse,
  output logic        write_lo,
  output logic        write_hi,
  output logic        read_cycle,
  output logic        TDL_EN,
  output logic        TRPLY
);

  localparam int unsigned DAL_W  = 22;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTL_W  = 4;
  localparam int unsigned CNT_W  = (READ_SETUP > 1) ? $clog2(READ_SETUP) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_WAIT, ST_READ, ST_RREPLY, ST_WRITE, ST_WREPLY, ST_IGNORE
  } state_t;

  // Two-stage synchronizers; control bits ordered {sync, din, dout, wtbt}
  logic [CTL_W-1:0] ctl_s1_q, ctl_s1_d, ctl_s2_q, ctl_s2_d;
  logic [DAL_W-1:0] dal_s1_q, dal_s1_d, dal_s2_q, dal_s2_d;
  logic             bs7_s1_q, bs7_s1_d, bs7_s2_q, bs7_s2_d;

  logic             sync_prev_q, sync_prev_d;
  logic [1:0]       fill_q, fill_d;
  logic             armed_q, armed_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DAL_W-1:0]  ral_q, ral_d;
  logic              rbs7_q, rbs7_d;
  logic [DATA_W-1:0] rdl_q, rdl_d;
  logic              write_pulse_q, write_pulse_d;
  logic              write_lo_q, write_lo_d;
  logic              write_hi_q, write_hi_d;
  logic              read_cycle_q, read_cycle_d;
  logic              tdl_en_q, tdl_en_d;
  logic              trply_q, trply_d;

  logic s_sync, s_din, s_dout, s_wtbt, sync_rise;

  assign s_sync = ctl_s2_q[3];
  assign s_din  = ctl_s2_q[2];
  assign s_dout = ctl_s2_q[1];
  assign s_wtbt = ctl_s2_q[0];

  // A SYNC that was already high through reset is not a new cycle: only
  // accept a rise once the synchronizers are full and SYNC has been seen low.
  assign sync_rise = armed_q & s_sync & ~sync_prev_q;

  // Next-state and output logic
  always_comb begin
    ctl_s1_d      = {BSYNC, BDIN, BDOUT, BWTBT};
    ctl_s2_d      = ctl_s1_q;
    dal_s1_d      = BDAL;
    dal_s2_d      = dal_s1_q;
    bs7_s1_d      = BBS7;
    bs7_s2_d      = bs7_s1_q;
    sync_prev_d   = s_sync;
    fill_d        = {fill_q[0], 1'b1};
    armed_d       = armed_q | (fill_q[1] & ~s_sync);

    state_d       = state_q;
    cnt_d         = cnt_q;
    ral_d         = ral_q;
    rbs7_d        = rbs7_q;
    rdl_d         = rdl_q;
    write_pulse_d = 1'b0;
    write_lo_d    = 1'b0;
    write_hi_d    = 1'b0;
    read_cycle_d  = read_cycle_q;
    tdl_en_d      = tdl_en_q;
    trply_d       = trply_q;

    if (state_q != ST_IDLE && !s_sync) begin
      // Master abort: release everything and wait for the next cycle
      state_d      = ST_IDLE;
      read_cycle_d = 1'b0;
      tdl_en_d     = 1'b0;
      trply_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync_rise) begin
            ral_d   = dal_s2_q;
            rbs7_d  = bs7_s2_q;
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: state_d = dev_match ? ST_WAIT : ST_IGNORE;
        ST_WAIT: begin
          if (s_din) begin
            state_d      = ST_READ;
            tdl_en_d     = 1'b1;
            read_cycle_d = 1'b1;
            cnt_d        = '0;
          end else if (s_dout) begin
            state_d = ST_WRITE;
            rdl_d   = dal_s2_q[DATA_W-1:0];
          end
        end
        ST_READ: begin
          if (cnt_q == CNT_W'(READ_SETUP - 1)) begin
            trply_d = 1'b1;
            state_d = ST_RREPLY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RREPLY: begin
          if (!s_din) begin
            trply_d      = 1'b0;
            tdl_en_d     = 1'b0;
            read_cycle_d = 1'b0;
            state_d      = ST_WAIT;
          end
        end
        ST_WRITE: begin
          write_pulse_d = 1'b1;
          write_lo_d    = s_wtbt ? ~ral_q[0] : 1'b1;
          write_hi_d    = s_wtbt ?  ral_q[0] : 1'b1;
          state_d       = ST_WREPLY;
        end
        ST_WREPLY: begin
          // Reply follows the strobe by one cycle
          if (!s_dout) begin
            trply_d = 1'b0;
            state_d = ST_WAIT;
          end else if (write_pulse_q) begin
            trply_d = 1'b1;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge qclk) begin
    if (reset) begin
      ctl_s1_q      <= '0;
      ctl_s2_q      <= '0;
      dal_s1_q      <= '0;
      dal_s2_q      <= '0;
      bs7_s1_q      <= 1'b0;
      bs7_s2_q      <= 1'b0;
      sync_prev_q   <= 1'b0;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ral_q         <= '0;
      rbs7_q        <= 1'b0;
      rdl_q         <= '0;
      write_pulse_q <= 1'b0;
      write_lo_q    <= 1'b0;
      write_hi_q    <= 1'b0;
      read_cycle_q  <= 1'b0;
      tdl_en_q      <= 1'b0;
      trply_q       <= 1'b0;
    end else begin
      ctl_s1_q      <= ctl_s1_d;
      ctl_s2_q      <= ctl_s2_d;
      dal_s1_q      <= dal_s1_d;
      dal_s2_q      <= dal_s2_d;
      bs7_s1_q      <= bs7_s1_d;
      bs7_s2_q      <= bs7_s2_d;
      sync_prev_q   <= sync_prev_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ral_q         <= ral_d;
      rbs7_q        <= rbs7_d;
      rdl_q         <= rdl_d;
      write_pulse_q <= write_pulse_d;
      write_lo_q    <= write_lo_d;
      write_hi_q    <= write_hi_d;
      read_cycle_q  <= read_cycle_d;
      tdl_en_q      <= tdl_en_d;
      trply_q       <= trply_d;
    end
  end

  assign RAL         = ral_q;
  assign RBS7        = rbs7_q;
  assign RDL         = rdl_q;
  assign write_pulse = write_pulse_q;
  assign write_lo    = write_lo_q;
  assign write_hi    = write_hi_q;
  assign read_cycle  = read_cycle_q;
  assign TDL_EN      = tdl_en_q;
  assign TRPLY       = trply_q;

endmodule

// File: tb/tb_qbus_slave_cycle.sv
// Testbench for qbus_slave_cycle: directed bus cycles followed by random
// transactions, checked against a cycle-count model of the bus protocol.
`timescale 1ns/1ps
module tb_qbus_slave_cycle;

  localparam int unsigned READ_SETUP = 2;
  // Bus line change -> registered reaction: 2 synchronizer flops + 1 register
  localparam int unsigned LAT = 3;

  logic        qclk = 1'b0;
  logic        reset;
  logic [21:0] BDAL;
  logic        BBS7, BSYNC, BDIN, BDOUT, BWTBT, dev_match;
  logic [21:0] RAL;
  logic        RBS7;
  logic [15:0] RDL;
  logic        write_pulse, write_lo, write_hi, read_cycle, TDL_EN, TRPLY;

  qbus_slave_cycle #(.READ_SETUP(READ_SETUP)) dut (
    .qclk(qclk), .reset(reset), .BDAL(BDAL), .BBS7(BBS7), .BSYNC(BSYNC),
    .BDIN(BDIN), .BDOUT(BDOUT), .BWTBT(BWTBT), .dev_match(dev_match),
    .RAL(RAL), .RBS7(RBS7), .RDL(RDL), .write_pulse(write_pulse),
    .write_lo(write_lo), .write_hi(write_hi), .read_cycle(read_cycle),
    .TDL_EN(TDL_EN), .TRPLY(TRPLY)
  );

  always #25 qclk = ~qclk;

  logic [5:0] outs;
  assign outs = {write_pulse, write_lo, write_hi, read_cycle, TDL_EN, TRPLY};

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [21:0] ral_exp  = '0;
  logic        rbs7_exp = 1'b0;
  logic [15:0] rdl_exp  = '0;
  logic        cur_match = 1'b0;
  int          exp_wp   = 0;
  int          exp_rply = 0;

  // Event monitor
  int   wp_seen   = 0;
  int   rply_seen = 0;
  logic trply_prev = 1'b0;
  always @(negedge qclk) begin
    if (write_pulse === 1'b1) wp_seen++;
    if (TRPLY === 1'b1 && trply_prev !== 1'b1) rply_seen++;
    trply_prev = TRPLY;
  end

  task automatic step();
    @(posedge qclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [21:0] addr, input logic bs7, input logic match);
    BDAL = addr; BBS7 = bs7; dev_match = match; BWTBT = 1'($urandom);
    step();
    BSYNC = 1'b1;
    repeat (LAT) step();
    ral_exp = addr; rbs7_exp = bs7; cur_match = match;
    chk("ral_latch", 32'(RAL), 32'(ral_exp));
    chk("rbs7_latch", 32'(RBS7), 32'(rbs7_exp));
    BDAL = 22'($urandom);
    BWTBT = 1'b0;
    repeat (1 + $urandom_range(0, 2)) step();
    chk("addr_quiet", 32'(outs), 32'(0));
  endtask

  task automatic din_phase();
    int unsigned hold;
    logic e, r;
    hold = LAT + READ_SETUP + $urandom_range(0, 3);
    BDIN = 1'b1;
    for (int k = 1; k <= int'(hold); k++) begin
      step();
      e = cur_match && (k >= int'(LAT));
      r = cur_match && (k >= int'(LAT + READ_SETUP));
      chk("dati_outs", 32'(outs), 32'({3'b000, e, e, r}));
    end
    if (cur_match) exp_rply++;
    BDIN = 1'b0;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      step();
      e = cur_match && (k < int'(LAT));
      chk("dati_release", 32'(outs), 32'({3'b000, e, e, e}));
    end
  endtask

  task automatic dout_phase(input logic [15:0] data, input logic byte_wr);
    int unsigned hold;
    logic [15:0] old_rdl;
    logic lo, hi, wp, r;
    hold = LAT + 2 + $urandom_range(0, 3);
    old_rdl = rdl_exp;
    lo = byte_wr ? ~ral_exp[0] : 1'b1;
    hi = byte_wr ?  ral_exp[0] : 1'b1;
    BDAL = {6'($urandom), data}; BWTBT = byte_wr; BDOUT = 1'b1;
    for (int k = 1; k <= int'(hold); k++) begin
      step();
      wp = cur_match && (k == int'(LAT) + 1);
      r  = cur_match && (k >= int'(LAT) + 2);
      chk("dato_outs", 32'(outs), 32'({wp, wp & lo, wp & hi, 2'b00, r}));
      chk("dato_rdl", 32'(RDL), 32'((cur_match && k >= int'(LAT)) ? data : old_rdl));
    end
    if (cur_match) begin
      rdl_exp = data; exp_wp++; exp_rply++;
    end
    BDOUT = 1'b0; BWTBT = 1'b0;
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      step();
      r = cur_match && (k < int'(LAT));
      chk("dato_release", 32'(outs), 32'({5'b00000, r}));
    end
  endtask

  task automatic end_cycle();
    BSYNC = 1'b0; BDIN = 1'b0; BDOUT = 1'b0;
    repeat (LAT + 1) step();
    chk("end_outs", 32'(outs), 32'(0));
    chk("end_ral_hold", 32'(RAL), 32'(ral_exp));
    chk("end_rbs7_hold", 32'(RBS7), 32'(rbs7_exp));
    chk("end_rdl_hold", 32'(RDL), 32'(rdl_exp));
  endtask

  initial begin
    int base_wp, base_rply, kind;
    logic [21:0] a;
    logic e;

    reset = 1'b1; BDAL = '0; BBS7 = 1'b0; BSYNC = 1'b0; BDIN = 1'b0;
    BDOUT = 1'b0; BWTBT = 1'b0; dev_match = 1'b0;
    repeat (3) step();
    chk("rst_outs", 32'(outs), 32'(0));
    chk("rst_ral", 32'(RAL), 32'(0));
    chk("rst_rbs7", 32'(RBS7), 32'(0));
    chk("rst_rdl", 32'(RDL), 32'(0));
    reset = 1'b0;
    repeat (3) step();

    // DATI to 17777570 with BS7
    addr_phase(22'o17777570, 1'b1, 1'b1);
    chk("dati_ral_const", 32'(RAL), 32'(22'o17777570));
    din_phase();
    end_cycle();

    // DATO word write
    addr_phase(22'o17777570, 1'b1, 1'b1);
    dout_phase(16'o123456, 1'b0);
    end_cycle();
    chk("dato_rdl_const", 32'(RDL), 32'(16'o123456));

    // DATOB odd then even address
    addr_phase(22'o17777571, 1'b1, 1'b1);
    dout_phase(16'h00a5, 1'b1);
    end_cycle();
    addr_phase(22'o17777570, 1'b1, 1'b1);
    dout_phase(16'h5a00, 1'b1);
    end_cycle();

    // DATIO: read then write within one SYNC
    base_wp = wp_seen; base_rply = rply_seen;
    addr_phase(22'o17777572, 1'b1, 1'b1);
    din_phase();
    dout_phase(16'hbeef, 1'b0);
    end_cycle();
    chk("datio_wp_count", 32'(wp_seen - base_wp), 32'(1));
    chk("datio_rply_count", 32'(rply_seen - base_rply), 32'(2));

    // No device match: stay silent through DIN and DOUT
    addr_phase(22'o17770000, 1'b1, 1'b0);
    din_phase();
    dout_phase(16'h1234, 1'b0);
    end_cycle();

    // SYNC negated mid-READ
    addr_phase(22'o17777570, 1'b1, 1'b1);
    BDIN = 1'b1;
    for (int k = 1; k <= int'(LAT + READ_SETUP) + 3; k++) begin
      step();
      e = (k >= int'(LAT)) && (k < int'(LAT + READ_SETUP));
      chk("abort_outs", 32'(outs), 32'({3'b000, e, e, 1'b0}));
      if (k == int'(READ_SETUP)) BSYNC = 1'b0;
    end
    end_cycle();

    // Reset in the middle of a DATI with SYNC and DIN held high
    addr_phase(22'o17777574, 1'b1, 1'b1);
    BDIN = 1'b1;
    repeat (LAT) step();
    chk("pre_reset_tdl", 32'(TDL_EN), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    ral_exp = '0; rbs7_exp = 1'b0; rdl_exp = '0;
    chk("midrst_outs", 32'(outs), 32'(0));
    chk("midrst_ral", 32'(RAL), 32'(0));
    chk("midrst_rdl", 32'(RDL), 32'(0));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_reset_silent", 32'(outs), 32'(0));
    end
    end_cycle();
    addr_phase(22'o17777576, 1'b0, 1'b1);
    din_phase();
    end_cycle();

    // Random transactions
    for (int n = 0; n < 20; n++) begin
      kind = int'($urandom_range(0, 4));
      a = 22'($urandom);
      addr_phase(a, 1'($urandom), kind != 4);
      case (kind)
        0: din_phase();
        1: dout_phase(16'($urandom), 1'b0);
        2: dout_phase(16'($urandom), 1'b1);
        3: begin din_phase(); dout_phase(16'($urandom), 1'($urandom)); end
        default: if ($urandom_range(0, 1) == 0) din_phase(); else dout_phase(16'($urandom), 1'b0);
      endcase
      end_cycle();
    end

    chk("total_write_pulses", 32'(wp_seen), 32'(exp_wp));
    chk("total_rply", 32'(rply_seen), 32'(exp_rply));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
